// File: rtl/lm32_dtlb_assoc.sv
// lm32_dtlb_assoc: N-way set-associative data TLB for the LM32 MMU.
// The lookup is indexed from the X-stage address and tag-compared in M.
// Fills update an existing matching entry, else the lowest invalid way,
// else the round-robin victim way.
// Optional feature macro: LM32_DTLB_ASID_EN (adds the asid port and ASID tagging).
module lm32_dtlb_assoc #(
  parameter int sets       = 256,
  parameter int ways       = 2,
  parameter int page_size  = 4096,
  parameter int asid_width = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable,
  input  logic        stall_x,
  input  logic        stall_m,
  input  logic [31:0] address_x,
  input  logic [31:0] address_m,
  input  logic        load_q_m,
  input  logic        store_q_m,
  input  logic [4:0]  csr,
  input  logic [31:0] csr_write_data,
  input  logic        csr_write_enable,
  input  logic        exception_m,
`ifdef LM32_DTLB_ASID_EN
  input  logic [asid_width-1:0] asid,
`endif
  output logic [31:0] physical_load_store_address_m,
  output logic        stall_request,
  output logic        miss_int,
  output logic [31:0] csr_read_data
);

  localparam logic [4:0] csr_tlb_vaddress = 5'h11;
  localparam logic [4:0] csr_tlb_paddress = 5'h12;
  localparam int off_w = $clog2(page_size);
  localparam int idx_w = $clog2(sets);
  localparam int tag_w = 32 - off_w - idx_w;
  localparam int pfn_w = 32 - off_w;
  localparam int way_w = (ways > 1) ? $clog2(ways) : 1;
`ifdef LM32_DTLB_ASID_EN
  localparam int a_w = asid_width;
`else
  localparam int a_w = 0;
  localparam int asid_width_unused = asid_width;
`endif
  // entry layout: {valid, tag, pfn[, asid]}
  localparam int entry_w = 1 + tag_w + pfn_w + a_w;

  typedef enum logic [2:0] {s_check, s_flush, s_upd_rd, s_upd_wr, s_restore} state_t;

  state_t               state;
  logic [idx_w-1:0]     flush_set;
  logic [way_w-1:0]     victim;
  logic                 miss_q;
  logic                 inv;
  logic [31:0]          update_vaddr;
  logic [31:0]          update_paddr;

  logic [ways-1:0][entry_w-1:0] rd;
  logic [ways-1:0][pfn_w-1:0]   rd_pfn;
  logic [ways-1:0]      rd_valid, way_hit, upd_match, we;
  logic [idx_w-1:0]     ra_next, wa;
  logic [entry_w-1:0]   wd, fill_entry;
  logic                 re, hit, miss, victim_inc;
  logic                 found_m, found_i;
  logic [way_w-1:0]     msel, isel, tsel;
  logic [pfn_w-1:0]     hit_pfn;

  wire [tag_w-1:0] tag_m   = address_m[31 -: tag_w];
  wire [tag_w-1:0] upd_tag = update_vaddr[31 -: tag_w];
  wire [idx_w-1:0] upd_idx = update_vaddr[off_w +: idx_w];
  wire [pfn_w-1:0] upd_pfn = update_paddr[31 -: pfn_w];

`ifdef LM32_DTLB_ASID_EN
  assign fill_entry = {1'b1, upd_tag, upd_pfn, asid};
`else
  assign fill_entry = {1'b1, upd_tag, upd_pfn};
`endif

  // per-way storage: registered read address, own write enable per way
  for (genvar w = 0; w < ways; w++) begin : g_way
    logic [entry_w-1:0] mem [sets];
    logic [idx_w-1:0]   ra;
    // RAM write and read-address register
    always_ff @(posedge clk_i) begin
      if (we[w]) mem[wa] <= wd;
      if (re) ra <= ra_next;
    end
    assign rd[w] = mem[ra];
  end

  // read port address selection by state
  always_comb begin
    re      = 1'b0;
    ra_next = address_x[off_w +: idx_w];
    case (state)
      s_check:   re = !stall_m;
      s_upd_rd:  begin re = 1'b1; ra_next = upd_idx; end
      s_restore: begin re = 1'b1; ra_next = address_m[off_w +: idx_w]; end
      default:   ;
    endcase
  end

  // field decode and tag compare for lookup and update
  always_comb begin
    for (int w = 0; w < ways; w++) begin
      rd_valid[w]  = rd[w][entry_w-1];
      rd_pfn[w]    = rd[w][a_w +: pfn_w];
      way_hit[w]   = rd_valid[w] && (rd[w][a_w+pfn_w +: tag_w] == tag_m);
      upd_match[w] = rd_valid[w] && (rd[w][a_w+pfn_w +: tag_w] == upd_tag);
`ifdef LM32_DTLB_ASID_EN
      way_hit[w]   = way_hit[w]   && (rd[w][0 +: a_w] == asid);
      upd_match[w] = upd_match[w] && (rd[w][0 +: a_w] == asid);
`endif
    end
  end

  // lowest-numbered hitting way wins
  always_comb begin
    hit     = 1'b0;
    hit_pfn = '0;
    for (int w = ways - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit     = 1'b1;
        hit_pfn = rd_pfn[w];
      end
    end
  end

  assign miss = enable && (load_q_m || store_q_m) && !hit && (state == s_check);
  assign miss_int = miss || miss_q;
  assign stall_request = (state != s_check);
  assign physical_load_store_address_m = enable ? {hit_pfn, address_m[off_w-1:0]} : address_m;

  // write control for flush and update; reset suppresses any in-flight write
  always_comb begin
    we = '0; wa = flush_set; wd = '0; victim_inc = 1'b0;
    found_m = 1'b0; found_i = 1'b0; msel = '0; isel = '0;
    for (int w = 0; w < ways; w++) begin
      if (!found_m && upd_match[w]) begin found_m = 1'b1; msel = way_w'(w); end
      if (!found_i && !rd_valid[w]) begin found_i = 1'b1; isel = way_w'(w); end
    end
    tsel = found_m ? msel : (found_i ? isel : victim);
    case (state)
      s_flush: we = '1;
      s_upd_wr: begin
        wa = upd_idx;
        if (inv) begin
          we = upd_match;
        end else begin
          we[tsel]   = 1'b1;
          wd         = fill_entry;
          victim_inc = !found_m && !found_i;
        end
      end
      default: ;
    endcase
    if (rst_i) we = '0;
  end

  // control FSM, CSR decode, miss tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= s_flush;
      flush_set     <= idx_w'(sets - 1);
      victim        <= '0;
      miss_q        <= 1'b0;
      inv           <= 1'b0;
      update_vaddr  <= '0;
      update_paddr  <= '0;
      csr_read_data <= '0;
    end else begin
      if (miss) miss_q <= 1'b1;
      else if (exception_m && miss_q) miss_q <= 1'b0;
      case (state)
        s_check: begin
          if (miss) csr_read_data <= address_m;
          if (csr_write_enable && csr_write_data[0]) begin
            if (csr == csr_tlb_vaddress) begin
              update_vaddr <= {csr_write_data[31:1], 1'b0};
              if (csr_write_data[5:1] == 5'd1) begin
                flush_set <= idx_w'(sets - 1);
                state     <= s_flush;
              end else if (csr_write_data[5:1] == 5'd2) begin
                inv   <= 1'b1;
                state <= s_upd_rd;
              end
            end else if (csr == csr_tlb_paddress) begin
              update_paddr <= {csr_write_data[31:1], 1'b0};
              inv          <= 1'b0;
              state        <= s_upd_rd;
            end
          end
        end
        s_flush: begin
          flush_set <= flush_set - 1'b1;
          if (flush_set == '0) state <= s_restore;
        end
        s_upd_rd: state <= s_upd_wr;
        s_upd_wr: begin
          if (victim_inc) victim <= (victim == way_w'(ways - 1)) ? '0 : victim + 1'b1;
          state <= s_restore;
        end
        s_restore: state <= s_check;
        default:   state <= s_flush;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, stall_x, address_x[off_w-1:0], address_x[31 -: tag_w],
                         update_vaddr[off_w-1:0], update_paddr[off_w-1:0]};

endmodule

// File: tb/tb_lm32_dtlb_assoc.sv
// Testbench for lm32_dtlb_assoc: directed table of fill/invalidate/lookup
// operations, reset/flush corner sequences, then randomized operations
// checked against a set/way array model of the TLB.
module tb_lm32_dtlb_assoc;
  localparam int SETS = 256;
  localparam int WAYS = 2;
  localparam logic [4:0] CSR_V = 5'h11;
  localparam logic [4:0] CSR_P = 5'h12;
  localparam int OP_LOOK = 0, OP_FILL = 1, OP_INV = 2;

  logic clk_i = 0, rst_i = 1, enable = 0, stall_x = 0, stall_m = 0;
  logic [31:0] address_x = 0, address_m = 0;
  logic load_q_m = 0, store_q_m = 0, csr_write_enable = 0, exception_m = 0;
  logic [4:0] csr = 0;
  logic [31:0] csr_write_data = 0;
`ifdef LM32_DTLB_ASID_EN
  logic [7:0] asid = 0;
`endif
  logic [31:0] phys, csr_read_data;
  logic stall_request, miss_int;

  lm32_dtlb_assoc #(.sets(SETS), .ways(WAYS), .page_size(4096), .asid_width(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable(enable), .stall_x(stall_x), .stall_m(stall_m),
    .address_x(address_x), .address_m(address_m), .load_q_m(load_q_m), .store_q_m(store_q_m),
    .csr(csr), .csr_write_data(csr_write_data), .csr_write_enable(csr_write_enable),
    .exception_m(exception_m),
`ifdef LM32_DTLB_ASID_EN
    .asid(asid),
`endif
    .physical_load_store_address_m(phys), .stall_request(stall_request),
    .miss_int(miss_int), .csr_read_data(csr_read_data));

  always #5 clk_i = ~clk_i;

  int vectors = 0, miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: plain per-set, per-way arrays and a single victim pointer
  bit          m_valid[SETS][WAYS];
  logic [11:0] m_tag[SETS][WAYS];
  logic [19:0] m_pfn[SETS][WAYS];
  int          m_victim = 0;

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
  endfunction

  function automatic void model_fill(input logic [31:0] va, input logic [31:0] pa);
    int s = int'(va[19:12]);
    int tgt = -1;
    for (int w = 0; w < WAYS; w++)
      if (tgt < 0 && m_valid[s][w] && m_tag[s][w] == va[31:20]) tgt = w;
    for (int w = 0; w < WAYS; w++)
      if (tgt < 0 && !m_valid[s][w]) tgt = w;
    if (tgt < 0) begin
      tgt = m_victim;
      m_victim = (m_victim + 1) % WAYS;
    end
    m_valid[s][tgt] = 1;
    m_tag[s][tgt] = va[31:20];
    m_pfn[s][tgt] = pa[31:12];
  endfunction

  function automatic void model_inval(input logic [31:0] va);
    int s = int'(va[19:12]);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == va[31:20]) m_valid[s][w] = 0;
  endfunction

  function automatic void model_lookup(input logic [31:0] va, output logic hit, output logic [31:0] pa);
    int s = int'(va[19:12]);
    hit = 0; pa = 0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (m_valid[s][w] && m_tag[s][w] == va[31:20]) begin
        hit = 1; pa = {m_pfn[s][w], va[11:0]};
      end
  endfunction

  task automatic csr_write(input logic [4:0] idx, input logic [31:0] d);
    @(negedge clk_i);
    csr = idx; csr_write_data = d; csr_write_enable = 1;
    @(negedge clk_i);
    csr_write_enable = 0;
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (stall_request && n < 2000) begin
      n++;
      @(negedge clk_i);
    end
  endtask

  task automatic fill(input logic [31:0] va, input logic [31:0] pa);
    int n;
    csr_write(CSR_V, {va[31:12], 12'h001});
    csr_write(CSR_P, {pa[31:12], 12'h001});
    count_stall(n);
    check("update stall cycles", n, 3);
    model_fill(va, pa);
  endtask

  task automatic inval(input logic [31:0] va);
    int n;
    csr_write(CSR_V, {va[31:12], 12'h005});
    count_stall(n);
    check("invalidate stall cycles", n, 3);
    model_inval(va);
  endtask

  // X-stage presentation, then M-stage load, then miss clearance via exception
  task automatic lookup(input logic [31:0] va, input logic en, input logic exp_miss,
                        input logic [31:0] exp_phys, input string nm);
    @(negedge clk_i);
    enable = en; address_x = va; load_q_m = 0;
    @(negedge clk_i);
    address_m = va; load_q_m = 1;
    #1;
    check({nm, " miss_int"}, 32'(miss_int), 32'(exp_miss));
    if (!exp_miss) check({nm, " phys"}, phys, exp_phys);
    @(negedge clk_i);
    load_q_m = 0;
    #1;
    check({nm, " miss_q"}, 32'(miss_int), 32'(exp_miss));
    if (exp_miss) check({nm, " badaddr"}, csr_read_data, va);
    exception_m = 1;
    @(negedge clk_i);
    exception_m = 0;
    #1;
    check({nm, " miss cleared"}, 32'(miss_int), 32'd0);
  endtask

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic        en;
    logic        miss;
    logic [31:0] exp_phys;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int n;
    logic h;
    logic [31:0] va, pa, ep;

    tbl.push_back('{OP_LOOK, 32'h00000ABC, 0, 1, 1, 0, "post-flush 0x0abc"});
    tbl.push_back('{OP_LOOK, 32'h00001000, 0, 1, 1, 0, "post-flush 0x1000"});
    tbl.push_back('{OP_FILL, 32'h00005000, 32'h80003000, 0, 0, 0, "fill 5"});
    tbl.push_back('{OP_LOOK, 32'h00005ABC, 0, 1, 0, 32'h80003ABC, "hit 5"});
    tbl.push_back('{OP_FILL, 32'h00105000, 32'h90000000, 0, 0, 0, "fill 105"});
    tbl.push_back('{OP_FILL, 32'h00205000, 32'hA0000000, 0, 0, 0, "fill 205"});
    tbl.push_back('{OP_LOOK, 32'h00005ABC, 0, 1, 1, 0, "evicted 5"});
    tbl.push_back('{OP_LOOK, 32'h00105ABC, 0, 1, 0, 32'h90000ABC, "hit 105"});
    tbl.push_back('{OP_LOOK, 32'h00205ABC, 0, 1, 0, 32'hA0000ABC, "hit 205"});
    tbl.push_back('{OP_FILL, 32'h00105000, 32'hB0000000, 0, 0, 0, "remap 105"});
    tbl.push_back('{OP_LOOK, 32'h00105ABC, 0, 1, 0, 32'hB0000ABC, "remapped 105"});
    tbl.push_back('{OP_LOOK, 32'h00205ABC, 0, 1, 0, 32'hA0000ABC, "kept 205"});
    tbl.push_back('{OP_INV,  32'h00105000, 0, 0, 0, 0, "inv 105"});
    tbl.push_back('{OP_LOOK, 32'h00105ABC, 0, 1, 1, 0, "invalidated 105"});
    tbl.push_back('{OP_LOOK, 32'h00205ABC, 0, 1, 0, 32'hA0000ABC, "still 205"});
    tbl.push_back('{OP_LOOK, 32'h12345678, 0, 0, 0, 32'h12345678, "bypass"});

    // reset state
    repeat (3) @(negedge clk_i);
    check("reset stall_request", 32'(stall_request), 32'd1);
    check("reset miss_int", 32'(miss_int), 32'd0);
    check("reset csr_read_data", csr_read_data, 32'd0);
    model_flush();

    // reset flush length, with an ignored PADDRESS write in the middle of it
    rst_i = 0;
    n = 0;
    csr = CSR_P; csr_write_data = 32'h80003001;
    while (stall_request && n < 2000) begin
      csr_write_enable = (n == 10);
      n++;
      @(negedge clk_i);
    end
    csr_write_enable = 0;
    check("reset flush cycles", n, SETS + 1);

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_FILL: fill(tbl[i].a, tbl[i].b);
        OP_INV:  inval(tbl[i].a);
        default: lookup(tbl[i].a, tbl[i].en, tbl[i].miss, tbl[i].exp_phys, tbl[i].nm);
      endcase
    end

    // reset asserted while the update is in UPD_WR
    csr_write(CSR_V, 32'h00305001);
    csr_write(CSR_P, 32'hC0000001);
    @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    check("mid-update reset csr_read_data", csr_read_data, 32'd0);
    count_stall(n);
    check("mid-update reset flush cycles", n, SETS + 1);
    model_flush();
    m_victim = 0;
    lookup(32'h00305ABC, 1, 1, 0, "aborted fill");
    lookup(32'h00205ABC, 1, 1, 0, "flushed 205");

    // randomized operations in a few colliding sets
    for (int i = 0; i < 200; i++) begin
      int r = $urandom_range(0, 9);
      va = 0;
      va[21:20] = 2'($urandom_range(0, 3));
      va[19:12] = 8'(5 + $urandom_range(0, 2));
      va[11:0]  = 12'($urandom);
      if (i == 100) begin
        csr_write(CSR_V, 32'h00000003);
        count_stall(n);
        check("csr flush cycles", n, SETS + 1);
        model_flush();
      end
      if (r < 4) begin
        pa = $urandom;
        fill(va, pa);
      end else if (r == 4) begin
        inval(va);
      end else if (r == 9) begin
        pa = $urandom;
        lookup(pa, 0, 0, pa, "rand bypass");
      end else begin
        model_lookup(va, h, ep);
        lookup(va, 1, !h, ep, "rand lookup");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
